exp_result_sink: RTL and testbench

- Consumer end of the valid/ready stream produced by the pipelined exp(x) Taylor evaluator.
- Accepts Q7.25 results and back-pressures the evaluator through its ready input.
- Buffers results in a small first-word-fall-through (FWFT) FIFO, tags each result with a sample index, and presents each result both raw (Q7.25) and narrowed to saturated Q2.14 on a downstream valid/ready port.

---
 rtl/exp_pkg.sv | 25 ++
 rtl/exp_sink_fifo.sv | 69 ++++++
 rtl/exp_result_sink.sv | 111 +++++++++++
 tb/tb_exp_result_sink.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared fixed-point constants, types and the Q7.25 -> Q2.14 saturating narrowing function
// for the exp(x) result path.
package exp_pkg;

  localparam int unsigned WIDTHIN    = 16;
  localparam int unsigned WIDTHOUT   = 32;
  localparam int unsigned Q_IN_FRAC  = 14;
  localparam int unsigned Q_OUT_FRAC = 25;

  // Fraction bits dropped when narrowing Q7.25 to Q2.14.
  localparam int unsigned NARROW_SHIFT = Q_OUT_FRAC - Q_IN_FRAC;

  typedef logic [WIDTHIN-1:0]  q2_14_t;
  typedef logic [WIDTHOUT-1:0] q7_25_t;

  // Returns {sat, x16}; anything >= 4.0 does not fit Q2.14 and clamps to all-ones.
  function automatic logic [WIDTHIN:0] q725_to_q214_sat(input q7_25_t y);
    logic   sat;
    q2_14_t x16;
    sat = |y[WIDTHOUT-1:Q_OUT_FRAC+2];
    x16 = sat ? '1 : y[NARROW_SHIFT +: WIDTHIN];
    return {sat, x16};
  endfunction

endpackage

// File: rtl/exp_sink_fifo.sv
// First-word-fall-through FIFO for exp_result_sink; synchronous active-low reset.
// Head data reads as zero while empty.
module exp_sink_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output logic                   ready,
  output logic                   valid,
  output entry_t                 rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Flags come from registered state only; a pop never frees room for a same-cycle push.
  assign ready   = count_q < CntW'(DEPTH);
  assign valid   = count_q != '0;
  assign push_ok = push && ready;
  assign pop_ok  = pop && valid;
  assign count   = count_q;
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/exp_result_sink.sv
// Sink for the exp(x) evaluator stream: buffers Q7.25 results in an FWFT FIFO, tags them with a
// sample index and narrows to saturated Q2.14. Optional stats under `EXP_SINK_STATS_EN.
module exp_result_sink #(
  parameter int unsigned WIDTHIN  = 16,
  parameter int unsigned WIDTHOUT = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNTW     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [WIDTHOUT-1:0]    i_y,
  output logic                   o_ready,
  output logic                   o_q_valid,
  input  logic                   i_q_ready,
  output logic [WIDTHOUT-1:0]    o_q_y,
  output logic [WIDTHIN-1:0]     o_q_x16,
  output logic                   o_q_sat,
  output logic [CNTW-1:0]        o_q_idx,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTHOUT-1:0]    o_max,
  output logic [CNTW-1:0]        o_sat_cnt
);

  import exp_pkg::*;

  localparam int unsigned FracOut = WIDTHOUT - 7;
  localparam int unsigned FracIn  = WIDTHIN - 2;
  localparam int unsigned Shift   = FracOut - FracIn;

  typedef struct packed {
    logic [WIDTHOUT-1:0] y;
    logic [WIDTHIN-1:0]  x16;
    logic                sat;
    logic [CNTW-1:0]     idx;
  } entry_t;

  logic               sat;
  logic [WIDTHIN-1:0] x16;
  logic               push_ok;
  logic [CNTW-1:0]    idx_q, idx_d;
  entry_t             wr_entry;
  entry_t             head;

  // Narrowing is combinational from i_y and captured at push time.
  if (WIDTHIN == exp_pkg::WIDTHIN && WIDTHOUT == exp_pkg::WIDTHOUT) begin : g_q725
    assign {sat, x16} = q725_to_q214_sat(i_y);
  end else begin : g_generic
    assign sat = |i_y[WIDTHOUT-1:FracOut+2];
    assign x16 = sat ? '1 : i_y[Shift +: WIDTHIN];
  end

  assign push_ok  = i_valid && o_ready;
  assign wr_entry = '{y: i_y, x16: x16, sat: sat, idx: idx_q};

  always_comb begin
    idx_d = idx_q;
    if (push_ok) idx_d = idx_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  exp_sink_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (i_valid),
    .wr_data (wr_entry),
    .pop     (i_q_ready),
    .ready   (o_ready),
    .valid   (o_q_valid),
    .rd_data (head),
    .count   (o_count)
  );

  assign o_q_y   = head.y;
  assign o_q_x16 = head.x16;
  assign o_q_sat = head.sat;
  assign o_q_idx = head.idx;

`ifdef EXP_SINK_STATS_EN
  logic [WIDTHOUT-1:0] max_q;
  logic [CNTW-1:0]     sat_cnt_q;

  // Saturating sample counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      max_q     <= '0;
      sat_cnt_q <= '0;
    end else if (push_ok) begin
      if (i_y > max_q) max_q <= i_y;
      if (sat && sat_cnt_q != '1) sat_cnt_q <= sat_cnt_q + CNTW'(1);
    end
  end

  assign o_max     = max_q;
  assign o_sat_cnt = sat_cnt_q;
`else
  assign o_max     = '0;
  assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_exp_result_sink.sv
// Self-checking bench for exp_result_sink: directed steps plus a randomized phase against a
// queue-based reference model. Stats checks follow `EXP_SINK_STATS_EN.
module tb_exp_result_sink;

  localparam int unsigned Depth = 8;
  localparam int unsigned Cntw  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_y;
  logic        o_ready;
  logic        o_q_valid;
  logic        i_q_ready;
  logic [31:0] o_q_y;
  logic [15:0] o_q_x16;
  logic        o_q_sat;
  logic [3:0]  o_q_idx;
  logic [3:0]  o_count;
  logic [31:0] o_max;
  logic [3:0]  o_sat_cnt;

  exp_result_sink #(
    .WIDTHIN  (16),
    .WIDTHOUT (32),
    .DEPTH    (Depth),
    .CNTW     (Cntw)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_y       (i_y),
    .o_ready   (o_ready),
    .o_q_valid (o_q_valid),
    .i_q_ready (i_q_ready),
    .o_q_y     (o_q_y),
    .o_q_x16   (o_q_x16),
    .o_q_sat   (o_q_sat),
    .o_q_idx   (o_q_idx),
    .o_count   (o_count),
    .o_max     (o_max),
    .o_sat_cnt (o_sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [15:0] x16;
    logic        sat;
    int          idx;
  } ent_t;

  ent_t        mq[$];
  int          m_idx;
  logic [31:0] m_max;
  int          m_sat_cnt;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing: values of 4.0 or more clamp, otherwise truncate to 14 fraction bits.
  function automatic ent_t model_entry(input logic [31:0] y, input int idx);
    ent_t e;
    e.y   = y;
    e.sat = (y >= 32'h0800_0000);
    e.x16 = e.sat ? 16'hFFFF : 16'((y / 2048) % 65536);
    e.idx = idx;
    return e;
  endfunction

  task automatic compare_all();
    chk("o_ready", o_ready, 64'(mq.size() < Depth));
    chk("o_q_valid", o_q_valid, 64'(mq.size() != 0));
    chk("o_count", o_count, 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("o_q_y", o_q_y, mq[0].y);
      chk("o_q_x16", o_q_x16, mq[0].x16);
      chk("o_q_sat", o_q_sat, mq[0].sat);
      chk("o_q_idx", o_q_idx, 64'(mq[0].idx));
    end
`ifdef EXP_SINK_STATS_EN
    chk("o_max", o_max, m_max);
    chk("o_sat_cnt", o_sat_cnt, 64'(m_sat_cnt));
`else
    chk("o_max", o_max, 64'd0);
    chk("o_sat_cnt", o_sat_cnt, 64'd0);
`endif
  endtask

  // One clock: drive, check pre-edge outputs on the falling edge, then advance the model.
  task automatic step(input logic v, input logic [31:0] y, input logic r);
    bit do_push;
    bit do_pop;
    i_valid   = v;
    i_y       = y;
    i_q_ready = r;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    do_push = v && (mq.size() < Depth);
    do_pop  = r && (mq.size() != 0);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      ent_t e;
      e = model_entry(y, m_idx);
      mq.push_back(e);
      m_idx = (m_idx + 1) % (1 << Cntw);
      if (y > m_max) m_max = y;
      if (e.sat && m_sat_cnt < (1 << Cntw) - 1) m_sat_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    i_valid = 1'b1;
    i_y     = 32'h0123_4567;
    @(posedge clk);
    mq.delete();
    m_idx     = 0;
    m_max     = '0;
    m_sat_cnt = 0;
    #1;
    reset   = 1'b1;
    i_valid = 1'b0;
    chk("rst_count", o_count, 64'd0);
    chk("rst_valid", o_q_valid, 64'd0);
    chk("rst_ready", o_ready, 64'd1);
    chk("rst_q_y", o_q_y, 64'd0);
    chk("rst_q_x16", o_q_x16, 64'd0);
    chk("rst_q_sat", o_q_sat, 64'd0);
    chk("rst_q_idx", o_q_idx, 64'd0);
    chk("rst_max", o_max, 64'd0);
    chk("rst_sat_cnt", o_sat_cnt, 64'd0);
  endtask

  function automatic logic [31:0] rand_y();
    return ($urandom_range(0, 1) != 0) ? 32'($urandom) : (32'($urandom) & 32'h0FFF_FFFF);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_valid   = 1'b0;
    i_y       = '0;
    i_q_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1.0 narrows to 0x4000
    step(1'b1, 32'h0200_0000, 1'b1);
    chk("t1_valid", o_q_valid, 64'd1);
    chk("t1_x16", o_q_x16, 64'h4000);
    chk("t1_sat", o_q_sat, 64'd0);
    chk("t1_idx", o_q_idx, 64'd0);

    // 5.0 saturates
    step(1'b1, 32'h0A00_0000, 1'b1);
    chk("t2_x16", o_q_x16, 64'hFFFF);
    chk("t2_sat", o_q_sat, 64'd1);
`ifdef EXP_SINK_STATS_EN
    chk("t2_sat_cnt", o_sat_cnt, 64'd1);
    chk("t2_max", o_max, 64'h0A00_0000);
`endif
    step(1'b0, '0, 1'b1);

    // Fill past full with the consumer stalled, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, rand_y(), 1'b0);
    chk("t3_count", o_count, 64'd8);
    chk("t3_ready", o_ready, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_idx", o_q_idx, 64'(i));
      step(1'b0, '0, 1'b1);
    end
    chk("t3_empty", o_q_valid, 64'd0);

    // Steady push+pop at count 3, then pop at full
    for (int i = 0; i < 3; i++) step(1'b1, rand_y(), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_y(), 1'b1);
      chk("t4_count3", o_count, 64'd3);
    end
    for (int i = 0; i < 5; i++) step(1'b1, rand_y(), 1'b0);
    chk("t4_full", o_count, 64'd8);
    chk("t4_full_ready", o_ready, 64'd0);
    step(1'b1, rand_y(), 1'b1);
    chk("t4_after_pop", o_count, 64'd7);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Index wraps modulo 2^CNTW
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, rand_y(), 1'b1);
    chk("t5_idx_wrap", o_q_idx, 64'd0);
    step(1'b0, '0, 1'b1);

    // Mid-stream reset discards everything
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rand_y(), 1'b0);
    chk("t6_count5", o_count, 64'd5);
    do_reset();
    step(1'b1, 32'h0100_0000, 1'b0);
    chk("t6_idx", o_q_idx, 64'd0);
    chk("t6_count", o_count, 64'd1);

    // Randomized traffic with a mix of in-range and saturating results
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_y(), 1'($urandom_range(0, 2) == 0 ? 0 : 1));
    end
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
